muldiv_iterative_unit: RTL

MULDIV_ITERATIVE_UNIT -- requirements
Module: muldiv_iterative_unit

---
 rtl/muldiv_iterative_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_iterative_unit.sv
// muldiv_iterative_unit: iterative RISC-V style multiply/divide unit.
// Multiply uses shift-add over absolute operand values, divide uses restoring
// division; both retire BITS_PER_CYCLE bits per clock, followed by a sign fix.
// Optional feature: define MULDIV_FASTPATH_EN to let divide-by-zero, signed
// overflow and multiply-by-zero skip the iteration and finish in one cycle.
module muldiv_iterative_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   hi;      // multiply: upper product / divide: partial remainder
  logic [XLEN-1:0]   lo;      // multiply: multiplier bits / divide: dividend -> quotient
  logic [XLEN-1:0]   opnd;    // multiplicand (mul) or divisor (div), absolute value
  logic              neg_res; // product / quotient must be negated at the end
  logic              neg_rem; // remainder must be negated at the end
  logic              div0;

  // Decode of the incoming request (used only at the accepting edge)
  logic            in_div;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  // Sign handling of the incoming operands
  always_comb begin
    in_div = op[2];
    a_sgn  = in_div ? ~op[0] : (op[1] ^ op[0]);
    b_sgn  = in_div ? ~op[0] : (op == 3'b001);
    a_neg  = a_sgn & operand_a[XLEN-1];
    b_neg  = b_sgn & operand_b[XLEN-1];
    a_abs  = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_abs  = b_neg ? (~operand_b + 1'b1) : operand_b;
  end

  // One CALC cycle worth of iteration: BITS_PER_CYCLE shift-add or restoring steps
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN-1:0] h, l;
  logic [XLEN:0]   r, sum;
  always_comb begin
    h   = hi;
    l   = lo;
    r   = '0;
    sum = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        r = {h, l[XLEN-1]};
        l = {l[XLEN-2:0], 1'b0};
        if (r >= {1'b0, opnd}) begin
          r    = r - {1'b0, opnd};
          l[0] = 1'b1;
        end
        h = r[XLEN-1:0];
      end else begin
        sum = {1'b0, h} + (l[0] ? {1'b0, opnd} : '0);
        l   = {sum[0], l[XLEN-1:1]};
        h   = sum[XLEN:1];
      end
    end
    step_hi = h;
    step_lo = l;
  end

  // Sign fix and result selection applied to the final iteration's output
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, calc_result;
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_res) prod = ~prod + 1'b1;
    quot = neg_res ? (~step_lo + 1'b1) : step_lo;
    if (div0) quot = '1;
    remv = neg_rem ? (~step_hi + 1'b1) : step_hi;
    if (op_q[2])
      calc_result = op_q[1] ? remv : quot;
    else
      calc_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_FASTPATH_EN
  // Early-out cases whose result is known without iterating
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;
  logic            in_div0, in_ovf;
  always_comb begin
    in_div0     = in_div && (operand_b == '0);
    in_ovf      = in_div && !op[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (operand_b == '1);
    fast_hit    = in_div0 || in_ovf ||
                  (!in_div && ((operand_a == '0) || (operand_b == '0)));
    fast_result = '0;
    if (in_div0)     fast_result = op[1] ? operand_a : '1;
    else if (in_ovf) fast_result = op[1] ? '0 : operand_a;
  end
`endif

  // Control FSM and datapath registers; flush beats both start and completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      div0        <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else if (state == CALC) begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(N - 1)) begin
        state       <= DONE;
        busy        <= 1'b0;
        valid       <= 1'b1;
        result      <= calc_result;
        div_by_zero <= div0;
      end
    end else if (start) begin
      cnt     <= '0;
      op_q    <= op;
      hi      <= '0;
      lo      <= in_div ? a_abs : b_abs;
      opnd    <= in_div ? b_abs : a_abs;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      div0    <= in_div && (operand_b == '0);
`ifdef MULDIV_FASTPATH_EN
      if (fast_hit) begin
        state       <= DONE;
        busy        <= 1'b0;
        valid       <= 1'b1;
        result      <= fast_result;
        div_by_zero <= in_div0;
      end else begin
        state <= CALC;
        busy  <= 1'b1;
        valid <= 1'b0;
      end
`else
      state <= CALC;
      busy  <= 1'b1;
      valid <= 1'b0;
`endif
    end else begin
      state <= IDLE;
      valid <= 1'b0;
    end
  end

endmodule
